button_debounce_bank: RTL and testbench

Multi-channel successor to the single reset-button debouncer. It synchronises `NUM_BTN` raw board buttons into the `clk_100mhz` domain and debounces both press and release edges. Per channel it produces a clean level, one-cycle press and release strobes, and an optional long-press strobe. It sits between the board button pins and the game control logic, alongside the reset generator.

---
 rtl/button_debounce_bank.sv | 160 ++++++++++++++++
 tb/tb_button_debounce_bank.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_bank.sv
// -----------------------------------------------------------------------------
// button_debounce_bank
//
// Brings NUM_BTN raw board buttons into the clk_100mhz domain and debounces
// both edges. Each channel gives a clean pressed level, one-cycle press and
// release strobes and, when built with the long-press option, a one-cycle
// long-press strobe.
//
// Build option:
//   BTN_LONG_PRESS_EN  defined   -> per-channel saturating hold counter; a
//                                   btn_long strobe after 2^LONG_WIDTH-1
//                                   cycles of debounced hold.
//                      undefined -> no hold counters, btn_long tied low.
//
// Parameters:
//   NUM_BTN     number of independent channels
//   CNT_WIDTH   debounce counter width, filter window = 2^CNT_WIDTH cycles
//   ACTIVE_LOW  1: pin low = pressed, 0: pin high = pressed
//   LONG_WIDTH  hold counter width (long-press option only)
//
// Ports:
//   clk_100mhz   system clock
//   pll_rst_n    asynchronous active-low reset
//   btn_raw      raw asynchronous button pins
//   btn_state    debounced level, 1 = pressed
//   btn_press    one-cycle strobe on btn_state 0->1
//   btn_release  one-cycle strobe on btn_state 1->0
//   btn_long     one-cycle strobe when a press has been held long enough
//   any_pressed  OR of btn_state
// -----------------------------------------------------------------------------
module button_debounce_bank #(
  parameter int NUM_BTN    = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_WIDTH = 24
) (
  input  logic               clk_100mhz,
  input  logic               pll_rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic               any_pressed
);

  // Synchronisers come out of reset holding the "released" pin level so no
  // phantom press is seen on the first cycles.
  localparam logic [1:0]           SYNC_RST = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [1:0]           sync_q [NUM_BTN];
  logic [1:0]           sync_d [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_BTN];
  logic [NUM_BTN-1:0]   state_q, state_d;
  logic [NUM_BTN-1:0]   press_q, press_d;
  logic [NUM_BTN-1:0]   release_q, release_d;
  logic [NUM_BTN-1:0]   s;

  // NOTE: every variable gets a default at the top of the loop body so no
  // path leaves it unassigned; that is what keeps this block latch-free.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      sync_d[i]    = {sync_q[i][0], btn_raw[i]};
      s[i]         = (ACTIVE_LOW != 0) ? ~sync_q[i][1] : sync_q[i][1];
      cnt_d[i]     = cnt_q[i];
      state_d[i]   = state_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;

      if (s[i] == state_q[i]) begin
        // Any agreeing sample restarts the filter window.
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else begin
        // Disagreement survived the whole window: accept the new level.
        state_d[i]   = s[i];
        cnt_d[i]     = '0;
        press_d[i]   = s[i];
        release_d[i] = ~s[i];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk_100mhz or negedge pll_rst_n) begin
    if (!pll_rst_n) begin
      // NOTE: the per-channel arrays are small flop banks, not RAM, so they
      // are reset element by element like any other register.
      for (int i = 0; i < NUM_BTN; i++) begin
        sync_q[i] <= SYNC_RST;
        cnt_q[i]  <= '0;
      end
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign any_pressed = |state_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] HOLD_MAX = '1;

  logic [LONG_WIDTH-1:0] hold_q [NUM_BTN];
  logic [LONG_WIDTH-1:0] hold_d [NUM_BTN];
  logic [NUM_BTN-1:0]    long_q, long_d;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_d[i] = hold_q[i];
      long_d[i] = 1'b0;
      if (!state_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HOLD_MAX) begin
        // Saturating count; the strobe fires only on the step that reaches
        // all-ones, so a long hold yields a single strobe.
        hold_d[i] = hold_q[i] + LONG_WIDTH'(1);
        long_d[i] = (hold_d[i] == HOLD_MAX);
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge pll_rst_n) begin
    if (!pll_rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= '0;
      end
      long_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= hold_d[i];
      end
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  // LONG_WIDTH has no meaning without the hold counters.
  logic unused_long_width;
  assign unused_long_width = ^LONG_WIDTH;
  assign btn_long          = '0;
`endif

endmodule

// File: tb/tb_button_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_bank
//
// Self-checking bench for button_debounce_bank (NUM_BTN=4, CNT_WIDTH=4,
// LONG_WIDTH=6, ACTIVE_LOW=1). A reference model working from per-edge sample
// history is compared against every output on every falling clock edge; a
// table of segments and a few hand-written sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_button_debounce_bank;

  localparam int NUM_BTN    = 4;
  localparam int CNT_WIDTH  = 4;
  localparam int LONG_WIDTH = 6;
  localparam int ACTIVE_LOW = 1;
  localparam int WIN        = 2 ** CNT_WIDTH;
  localparam int LONG_TH    = 2 ** LONG_WIDTH - 1;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic               clk_100mhz = 1'b0;
  logic               pll_rst_n;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_state, btn_press, btn_release, btn_long;
  logic               any_pressed;

  button_debounce_bank #(
    .NUM_BTN   (NUM_BTN),
    .CNT_WIDTH (CNT_WIDTH),
    .ACTIVE_LOW(ACTIVE_LOW),
    .LONG_WIDTH(LONG_WIDTH)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .pll_rst_n  (pll_rst_n),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .any_pressed(any_pressed)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. hist[e] is the normalised pin level sampled at edge e
  // (edges counted from reset release). The level the filter sees at edge e is
  // the pin sampled two edges earlier. A channel flips at edge t when the last
  // WIN seen levels since the last flip/reset all disagree with its state.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] hist [$];
  int                 t_edge = 0;
  int                 win_start [NUM_BTN] = '{default: 0};
  int                 rise_edge [NUM_BTN] = '{default: -1};
  logic [NUM_BTN-1:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;

  function automatic logic seen_at(input int e, input int ch);
    logic [NUM_BTN-1:0] v;
    if (e < 2) return 1'b0;
    v = hist[e-2];
    return v[ch];
  endfunction

  task automatic model_reset();
    hist.delete();
    t_edge  = 0;
    m_state = '0;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int ch = 0; ch < NUM_BTN; ch++) begin
      win_start[ch] = 0;
      rise_edge[ch] = -1;
    end
  endtask

  task automatic model_step();
    logic [NUM_BTN-1:0] ns;
    bit                 flip;
    ns      = m_state;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    hist.push_back((ACTIVE_LOW != 0) ? ~btn_raw : btn_raw);
    for (int ch = 0; ch < NUM_BTN; ch++) begin
      if (LONG_EN && m_state[ch] && (t_edge - rise_edge[ch] == LONG_TH)) m_long[ch] = 1'b1;
      flip = 1'b1;
      for (int j = 0; j < WIN; j++) begin
        if ((t_edge - j) < win_start[ch] || seen_at(t_edge - j, ch) == m_state[ch]) flip = 1'b0;
      end
      if (flip) begin
        ns[ch]        = ~m_state[ch];
        win_start[ch] = t_edge + 1;
        if (ns[ch]) begin
          m_press[ch]   = 1'b1;
          rise_edge[ch] = t_edge;
        end else begin
          m_rel[ch]     = 1'b1;
          rise_edge[ch] = -1;
        end
      end
    end
    m_state = ns;
    t_edge++;
  endtask

  initial begin
    forever begin
      @(posedge clk_100mhz or negedge pll_rst_n);
      if (!pll_rst_n) model_reset();
      else            model_step();
    end
  end

  // Continuous comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk_100mhz);
      check("model_state",   btn_state,   m_state);
      check("model_press",   btn_press,   m_press);
      check("model_release", btn_release, m_rel);
      check("model_long",    btn_long,    m_long);
      check("model_any",     any_pressed, |m_state);
    end
  end

  // ---------------------------------------------------------------------------
  // Segment driver with strobe accumulation.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] acc_press, acc_rel, acc_long;
  int                 acc_press_n, acc_rel_n, acc_long_n;

  task automatic clear_acc();
    acc_press   = '0;
    acc_rel     = '0;
    acc_long    = '0;
    acc_press_n = 0;
    acc_rel_n   = 0;
    acc_long_n  = 0;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_seg(input logic [NUM_BTN-1:0] raw, input int n);
    btn_raw = raw;
    repeat (n) begin
      @(negedge clk_100mhz);
      acc_press   |= btn_press;
      acc_rel     |= btn_release;
      acc_long    |= btn_long;
      acc_press_n += $countones(btn_press);
      acc_rel_n   += $countones(btn_release);
      acc_long_n  += $countones(btn_long);
    end
    #1;
  endtask

  typedef struct {
    logic [NUM_BTN-1:0] raw;
    int                 cycles;
    logic [NUM_BTN-1:0] press_or;
    int                 press_n;
    logic [NUM_BTN-1:0] rel_or;
    int                 rel_n;
    logic [NUM_BTN-1:0] long_or;
    int                 long_n;
    logic [NUM_BTN-1:0] end_state;
  } seg_t;

  seg_t vecs [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_BTN-1:0] cur;
    int                 hold_left [NUM_BTN];
    logic               prev_any;
    bit                 found;

    btn_raw   = '0;
    pll_rst_n = 1'b0;

    //          raw      cyc  press_or pn rel_or  rn long_or                    ln                   end
    vecs[0]  = '{4'b1110,  40, 4'b0001, 1, 4'b0000, 0, 4'b0000,                  0,                   4'b0001};
    vecs[1]  = '{4'b1111,  30, 4'b0000, 0, 4'b0001, 1, 4'b0000,                  0,                   4'b0000};
    vecs[2]  = '{4'b1011, 200, 4'b0100, 1, 4'b0000, 0, LONG_EN ? 4'b0100 : 4'b0, LONG_EN ? 1 : 0,     4'b0100};
    vecs[3]  = '{4'b1111,  30, 4'b0000, 0, 4'b0100, 1, 4'b0000,                  0,                   4'b0000};
    vecs[4]  = '{4'b1011,  50, 4'b0100, 1, 4'b0000, 0, 4'b0000,                  0,                   4'b0100};
    vecs[5]  = '{4'b1111,  30, 4'b0000, 0, 4'b0100, 1, 4'b0000,                  0,                   4'b0000};
    vecs[6]  = '{4'b1101,  15, 4'b0000, 0, 4'b0000, 0, 4'b0000,                  0,                   4'b0000};
    vecs[7]  = '{4'b1111,  30, 4'b0000, 0, 4'b0000, 0, 4'b0000,                  0,                   4'b0000};
    vecs[8]  = '{4'b1101,  16, 4'b0000, 0, 4'b0000, 0, 4'b0000,                  0,                   4'b0000};
    vecs[9]  = '{4'b1111,  40, 4'b0010, 1, 4'b0010, 1, 4'b0000,                  0,                   4'b0000};
    vecs[10] = '{4'b0110,  30, 4'b1001, 2, 4'b0000, 0, 4'b0000,                  0,                   4'b1001};
    vecs[11] = '{4'b1111,  30, 4'b0000, 0, 4'b1001, 2, 4'b0000,                  0,                   4'b0000};

    // Reset with every button held: outputs stay 0, then all four debounce.
    repeat (3) @(negedge clk_100mhz);
    #1;
    check("rst_state",   btn_state,   '0);
    check("rst_press",   btn_press,   '0);
    check("rst_release", btn_release, '0);
    check("rst_long",    btn_long,    '0);
    check("rst_any",     any_pressed, '0);
    pll_rst_n = 1'b1;
    repeat (17) @(negedge clk_100mhz);
    check("held_press_k16", btn_press, 4'b0000);
    @(negedge clk_100mhz);
    check("held_press_k17", btn_press,   4'b1111);
    check("held_state_k17", btn_state,   4'b1111);
    check("held_any_k17",   any_pressed, 1'b1);
    @(negedge clk_100mhz);
    check("held_press_k18", btn_press, 4'b0000);
    #1;
    run_seg(4'b1111, 30);

    // Table of segments.
    for (int i = 0; i < 12; i++) begin
      clear_acc();
      run_seg(vecs[i].raw, vecs[i].cycles);
      check($sformatf("seg%0d_press_or", i),  acc_press,   vecs[i].press_or);
      check($sformatf("seg%0d_press_n", i),   acc_press_n, vecs[i].press_n);
      check($sformatf("seg%0d_rel_or", i),    acc_rel,     vecs[i].rel_or);
      check($sformatf("seg%0d_rel_n", i),     acc_rel_n,   vecs[i].rel_n);
      check($sformatf("seg%0d_long_or", i),   acc_long,    vecs[i].long_or);
      check($sformatf("seg%0d_long_n", i),    acc_long_n,  vecs[i].long_n);
      check($sformatf("seg%0d_end_state", i), btn_state,   vecs[i].end_state);
    end

    // Bounce on ch1: toggle every 5 cycles for 100 cycles, ending released.
    clear_acc();
    for (int j = 0; j < 20; j++) run_seg((j % 2 == 0) ? 4'b1101 : 4'b1111, 5);
    run_seg(4'b1111, 30);
    check("bounce_press",   acc_press_n, 0);
    check("bounce_release", acc_rel_n,   0);
    check("bounce_state1",  btn_state[1], 1'b0);

    // Reset in the middle of a ch3 debounce while ch0 is already pressed.
    run_seg(4'b1110, 30);
    check("mid_pre_state", btn_state, 4'b0001);
    btn_raw = 4'b0110;
    repeat (12) @(negedge clk_100mhz);
    #1;
    pll_rst_n = 1'b0;
    #1;
    check("mid_rst_state",   btn_state,   '0);
    check("mid_rst_any",     any_pressed, '0);
    check("mid_rst_press",   btn_press,   '0);
    check("mid_rst_release", btn_release, '0);
    check("mid_rst_long",    btn_long,    '0);
    btn_raw = 4'b1111;
    repeat (2) @(negedge clk_100mhz);
    #1;
    pll_rst_n = 1'b1;
    clear_acc();
    run_seg(4'b1111, 100);
    check("mid_after_press",   acc_press, '0);
    check("mid_after_release", acc_rel,   '0);

    // Simultaneous press on ch0 and ch3.
    btn_raw  = 4'b0110;
    prev_any = any_pressed;
    found    = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk_100mhz);
      if (btn_press != '0) begin
        found = 1'b1;
        check("simul_press",    btn_press,   4'b1001);
        check("simul_any_now",  any_pressed, 1'b1);
        check("simul_any_prev", prev_any,    1'b0);
      end else begin
        prev_any = any_pressed;
      end
    end
    check("simul_found", found, 1'b1);
    @(negedge clk_100mhz);
    check("simul_press_next", btn_press, 4'b0000);
    #1;
    run_seg(4'b1111, 30);

    // Randomised holds per channel, with one reset pulse in the middle.
    cur = 4'b1111;
    for (int ch = 0; ch < NUM_BTN; ch++) hold_left[ch] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NUM_BTN; ch++) begin
        if (hold_left[ch] == 0) begin
          cur[ch]       = ~cur[ch];
          hold_left[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 110)
                                                      : $urandom_range(1, 24);
        end else begin
          hold_left[ch]--;
        end
      end
      btn_raw   = cur;
      pll_rst_n = (c >= 1500 && c < 1503) ? 1'b0 : 1'b1;
      @(negedge clk_100mhz);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
